// File: rtl/calibration_pattern_tx_if.sv
// Request/response bundle between the calibration step FSM and the pattern
// transmitter.
//   master: start, bit_index, pattern_mode, on_color   -> transmitter
//   slave : strand_out, busy, displayed_frame_valid    -> step FSM / strand
interface calibration_pattern_tx_if #(
    parameter int unsigned LED_ADDRESS_WIDTH = 10
);
    localparam int unsigned BIT_IDX_WIDTH = $clog2(LED_ADDRESS_WIDTH);

    logic                     start;
    logic [BIT_IDX_WIDTH-1:0] bit_index;
    logic [1:0]               pattern_mode;
    logic [23:0]              on_color;
    logic                     strand_out;
    logic                     busy;
    logic                     displayed_frame_valid;

    modport master (
        output start, bit_index, pattern_mode, on_color,
        input  strand_out, busy, displayed_frame_valid
    );

    modport slave (
        input  start, bit_index, pattern_mode, on_color,
        output strand_out, busy, displayed_frame_valid
    );
endinterface

// File: rtl/calibration_pattern_tx.sv
// Calibration pattern transmitter: on each accepted start, sends one
// WS2812-style frame in which LED i is lit iff bit bit_index of i (optionally
// complemented) is set, then holds the line low for the strand latch time
// and raises displayed_frame_valid.
//   clk_pixel, rst_n (async, active-low)
//   bus.slave: start/bit_index/pattern_mode/on_color in,
//              strand_out/busy/displayed_frame_valid out (all registered)
module calibration_pattern_tx #(
    parameter int unsigned NUM_LEDS          = 50,
    parameter int unsigned LED_ADDRESS_WIDTH = 10,
    parameter int unsigned T0H_CYCLES        = 30,
    parameter int unsigned T1H_CYCLES        = 59,
    parameter int unsigned BIT_CYCLES        = 93,
    parameter int unsigned RESET_CYCLES      = 22275
) (
    input  logic                   clk_pixel,
    input  logic                   rst_n,
    calibration_pattern_tx_if.slave bus
);
    localparam int unsigned BIT_IDX_WIDTH = $clog2(LED_ADDRESS_WIDTH);
    localparam int unsigned LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned CYC_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES - 1
                                                                  : RESET_CYCLES - 1;
    localparam int unsigned CYC_W   = (CYC_MAX > 0) ? $clog2(CYC_MAX + 1) : 1;

    typedef enum logic [2:0] {
        SETTLE,
        IDLE,
        SEND_HIGH,
        SEND_LOW,
        LATCH,
        DONE
    } state_e;

    state_e                   state_q;
    logic [LED_W-1:0]         led_cnt_q;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic [CYC_W-1:0]         cyc_cnt_q;
    logic                     pending_q;
    logic [BIT_IDX_WIDTH-1:0] bit_idx_q;
    logic [1:0]               mode_q;
    logic [23:0]              color_q;
    logic                     strand_out_q;
    logic                     busy_q;
    logic                     valid_q;

    logic [LED_ADDRESS_WIDTH-1:0] led_id_c;
    logic                         id_bit_c;
    logic                         lit_c;
    logic [23:0]                  color_shift_c;
    logic                         bit_val_c;
    logic [CYC_W-1:0]             high_last_c;
    logic                         open_c;
    logic                         accept_c;

    // Current bit value and the high time it needs; an index past the ID
    // width shifts everything out, so it reads as 0.
    always_comb begin
        led_id_c      = LED_ADDRESS_WIDTH'(led_cnt_q) >> bit_idx_q;
        id_bit_c      = |(led_id_c & LED_ADDRESS_WIDTH'(1));
        case (mode_q)
            2'd0:    lit_c = id_bit_c;
            2'd1:    lit_c = ~id_bit_c;
            2'd2:    lit_c = 1'b0;
            default: lit_c = 1'b1;
        endcase
        color_shift_c = color_q << bit_cnt_q;
        bit_val_c     = lit_c & (|(color_shift_c & 24'h800000));
        high_last_c   = bit_val_c ? CYC_W'(T1H_CYCLES - 1) : CYC_W'(T0H_CYCLES - 1);
        open_c        = (state_q == IDLE) || (state_q == DONE);
        accept_c      = open_c && (bus.start || pending_q);
    end

    // Frame FSM. The line is a registered copy of "state is SEND_HIGH", so the
    // wire trails the FSM by one cycle; valid likewise rises one cycle after
    // DONE, exactly when the line has been low for the full latch time.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SETTLE;
            led_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            cyc_cnt_q    <= '0;
            pending_q    <= 1'b0;
            bit_idx_q    <= '0;
            mode_q       <= 2'd0;
            color_q      <= 24'h000000;
            strand_out_q <= 1'b0;
            busy_q       <= 1'b1;
            valid_q      <= 1'b0;
        end else begin
            strand_out_q <= (state_q == SEND_HIGH);

            // Request fields are captured only while a start can be honoured.
            if (bus.start && (open_c || (state_q == SETTLE))) begin
                bit_idx_q <= bus.bit_index;
                mode_q    <= bus.pattern_mode;
                color_q   <= bus.on_color;
            end

            case (state_q)
                SETTLE: begin
                    if (bus.start) begin
                        pending_q <= 1'b1;
                    end
                    if (cyc_cnt_q == CYC_W'(RESET_CYCLES - 1)) begin
                        cyc_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
                    end
                end
                IDLE, DONE: begin
                    if (accept_c) begin
                        pending_q <= 1'b0;
                        led_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        cyc_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b0;
                        state_q   <= SEND_HIGH;
                    end else begin
                        busy_q  <= 1'b0;
                        valid_q <= (state_q == DONE);
                    end
                end
                SEND_HIGH: begin
                    cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
                    if (cyc_cnt_q == high_last_c) begin
                        state_q <= SEND_LOW;
                    end
                end
                SEND_LOW: begin
                    // The cycle counter runs across both halves, so every bit
                    // period is exactly BIT_CYCLES long.
                    if (cyc_cnt_q == CYC_W'(BIT_CYCLES - 1)) begin
                        cyc_cnt_q <= '0;
                        state_q   <= SEND_HIGH;
                        if (bit_cnt_q == BIT_W'(23)) begin
                            bit_cnt_q <= '0;
                            if (led_cnt_q == LED_W'(NUM_LEDS - 1)) begin
                                state_q <= LATCH;
                            end else begin
                                led_cnt_q <= led_cnt_q + LED_W'(1);
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
                    end
                end
                LATCH: begin
                    if (cyc_cnt_q == CYC_W'(RESET_CYCLES - 1)) begin
                        cyc_cnt_q <= '0;
                        state_q   <= DONE;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
                    end
                end
                default: begin
                    state_q <= SETTLE;
                end
            endcase
        end
    end

    assign bus.strand_out            = strand_out_q;
    assign bus.busy                  = busy_q;
    assign bus.displayed_frame_valid = valid_q;
endmodule

// File: tb/tb_calibration_pattern_tx.sv
module tb_calibration_pattern_tx;
    localparam int unsigned N      = 4;
    localparam int unsigned LED_AW = 10;
    localparam int unsigned T0H    = 2;
    localparam int unsigned T1H    = 4;
    localparam int unsigned BITC   = 6;
    localparam int unsigned RSTC   = 10;
    localparam int unsigned FRAME  = N * 24 * BITC;        // 576
    localparam int unsigned VRISE  = FRAME + RSTC + 1;     // 587
    localparam int unsigned TAIL   = 20;
    localparam int unsigned NS     = VRISE + TAIL;
    localparam int unsigned NVEC   = 8;

    typedef struct packed {
        logic [1:0]   mode;
        logic [3:0]   idx;
        logic [23:0]  color;
        logic [N-1:0] mask;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs [NVEC];

    calibration_pattern_tx_if #(.LED_ADDRESS_WIDTH(LED_AW)) bus ();

    calibration_pattern_tx #(
        .NUM_LEDS         (N),
        .LED_ADDRESS_WIDTH(LED_AW),
        .T0H_CYCLES       (T0H),
        .T1H_CYCLES       (T1H),
        .BIT_CYCLES       (BITC),
        .RESET_CYCLES     (RSTC)
    ) dut (
        .clk_pixel(clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: which LEDs are lit for a request.
    function automatic logic model_lit(input int i, input logic [1:0] m, input logic [3:0] idx);
        logic id_bit;
        id_bit = 1'b0;
        if (int'(idx) < int'(LED_AW)) id_bit = ((i >> idx) % 2) == 1;
        case (m)
            2'd0:    return id_bit;
            2'd1:    return !id_bit;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [N-1:0] model_mask(input logic [1:0] m, input logic [3:0] idx);
        logic [N-1:0] r;
        for (int i = 0; i < int'(N); i++) r[i] = model_lit(i, m, idx);
        return r;
    endfunction

    // Reference: serial bit j of the frame (LED-major, colour MSB first).
    function automatic logic model_bit(input int j, input logic [1:0] m, input logic [3:0] idx,
                                       input logic [23:0] col);
        int i;
        int b;
        i = j / 24;
        b = 23 - (j % 24);
        return model_lit(i, m, idx) && col[b];
    endfunction

    task automatic issue(input logic [1:0] m, input logic [3:0] idx, input logic [23:0] col);
        bus.start = 1'b1; bus.pattern_mode = m; bus.bit_index = idx; bus.on_color = col;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.pattern_mode = ~m; bus.bit_index = ~idx; bus.on_color = ~col;
    endtask

    // Sample k is taken 1 time unit after edge e0+k, e0 being the acceptance edge.
    task automatic capture(input string name, input int unsigned e0, input logic [1:0] m,
                           input logic [3:0] idx, input logic [23:0] col, input logic [N-1:0] mask);
        logic [NS:0] sw;
        logic [NS:0] bw;
        logic [NS:0] vw;
        int s_err, b_err, v_err, first_s;
        s_err = 0; b_err = 0; v_err = 0; first_s = -1;
        while (cyc < e0) begin @(posedge clk); #1; end
        for (int k = 0; k <= int'(NS); k++) begin
            sw[k] = bus.strand_out; bw[k] = bus.busy; vw[k] = bus.displayed_frame_valid;
            if (k < int'(NS)) begin @(posedge clk); #1; end
        end
        check({name, "/valid_fall"}, 32'(vw[0]), 32'd0);
        for (int k = 0; k <= int'(NS); k++) begin
            logic es;
            es = 1'b0;
            if (k >= 1 && k <= int'(FRAME)) begin
                int j, p, hi;
                j  = (k - 1) / int'(BITC);
                p  = (k - 1) % int'(BITC);
                hi = model_bit(j, m, idx, col) ? int'(T1H) : int'(T0H);
                es = p < hi;
            end
            if (sw[k] !== es) begin s_err++; if (first_s < 0) first_s = k; end
            if (bw[k] !== (k < int'(VRISE))) b_err++;
            if (vw[k] !== (k >= int'(VRISE))) v_err++;
        end
        check($sformatf("%s/strand_wave(first_bad=%0d)", name, first_s), 32'(s_err), 32'd0);
        check({name, "/busy_wave"}, 32'(b_err), 32'd0);
        check({name, "/valid_wave"}, 32'(v_err), 32'd0);
        check({name, "/valid_at_latency"}, 32'(vw[VRISE]), 32'd1);
        for (int i = 0; i < int'(N); i++) begin
            logic [23:0] val;
            val = 24'h0;
            for (int jj = 0; jj < 24; jj++) begin
                int hc, j;
                hc = 0;
                j  = i * 24 + jj;
                for (int p = 0; p < int'(BITC); p++) hc += int'(sw[1 + j * int'(BITC) + p]);
                val = {val[22:0], (hc == int'(T1H))};
            end
            check($sformatf("%s/led%0d", name, i), 32'(val), 32'(mask[i] ? col : 24'h0));
        end
    endtask

    task automatic settle_frame(input string name, input int start_edge, input logic [1:0] m,
                                input logic [3:0] idx, input logic [23:0] col, input logic [N-1:0] mask);
        int unsigned rel;
        int s_err, b_err;
        s_err = 0; b_err = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        for (int k = 1; k <= int'(RSTC); k++) begin
            if (k == start_edge) begin
                bus.start = 1'b1; bus.pattern_mode = m; bus.bit_index = idx; bus.on_color = col;
            end
            @(posedge clk); #1;
            if (k == start_edge) begin
                bus.start = 1'b0; bus.pattern_mode = ~m; bus.bit_index = ~idx; bus.on_color = ~col;
            end
            if (bus.strand_out !== 1'b0) s_err++;
            if (bus.busy !== 1'b1) b_err++;
        end
        check({name, "/settle_line_low"}, 32'(s_err), 32'd0);
        check({name, "/settle_busy"}, 32'(b_err), 32'd0);
        capture(name, rel + RSTC + 1, m, idx, col, mask);
    endtask

    initial begin
        logic [1:0]  rm;
        logic [3:0]  ri;
        logic [23:0] rc;
        int unsigned e0;

        rst_n = 1'b1;
        bus.start = 1'b0; bus.bit_index = '0; bus.pattern_mode = 2'd0; bus.on_color = 24'h0;

        //            mode   idx    colour      lit mask (LED3..LED0)
        vecs[0] = {2'd0, 4'd1,  24'hFFFFFF, 4'b1100};
        vecs[1] = {2'd3, 4'd0,  24'h800001, 4'b1111};
        vecs[2] = {2'd1, 4'd0,  24'h00FF00, 4'b0101};
        vecs[3] = {2'd0, 4'd0,  24'hA5C3E1, 4'b1010};
        vecs[4] = {2'd2, 4'd3,  24'hFFFFFF, 4'b0000};
        vecs[5] = {2'd0, 4'd12, 24'hFFFFFF, 4'b0000};
        vecs[6] = {2'd1, 4'd12, 24'h123456, 4'b1111};
        vecs[7] = {2'd1, 4'd1,  24'h0F0F0F, 4'b0011};

        #2 rst_n = 1'b0;
        #2;
        check("reset/strand_out", 32'(bus.strand_out), 32'd0);
        check("reset/busy", 32'(bus.busy), 32'd1);
        check("reset/valid", 32'(bus.displayed_frame_valid), 32'd0);

        // Start pulsed during SETTLE is held pending and serviced on entering IDLE.
        settle_frame("settle_pending", 3, vecs[0].mode, vecs[0].idx, vecs[0].color, vecs[0].mask);

        for (int t = 1; t < int'(NVEC); t++) begin
            issue(vecs[t].mode, vecs[t].idx, vecs[t].color);
            capture($sformatf("vec%0d", t), cyc, vecs[t].mode, vecs[t].idx, vecs[t].color, vecs[t].mask);
        end

        for (int r = 0; r < 3; r++) begin
            rm = 2'($urandom_range(0, 3));
            ri = 4'($urandom_range(0, 15));
            rc = 24'($urandom);
            issue(rm, ri, rc);
            capture($sformatf("rand%0d", r), cyc, rm, ri, rc, model_mask(rm, ri));
        end

        // A start arriving mid-frame (SEND_LOW of LED0 bit 20) must be dropped.
        issue(2'd0, 4'd0, 24'hFFFFFF);
        e0 = cyc;
        fork
            capture("busy_start_ignored", e0, 2'd0, 4'd0, 24'hFFFFFF, model_mask(2'd0, 4'd0));
            begin
                repeat (21) @(posedge clk);
                #1;
                bus.start = 1'b1; bus.pattern_mode = 2'd2; bus.bit_index = 4'd1; bus.on_color = 24'h0;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        join

        // Reset in the middle of a high pulse of LED 2 clears outputs at once.
        issue(2'd3, 4'd0, 24'hFFFFFF);
        repeat (290) @(posedge clk);
        #1;
        check("midreset/line_high_before", 32'(bus.strand_out), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midreset/strand_out", 32'(bus.strand_out), 32'd0);
        check("midreset/valid", 32'(bus.displayed_frame_valid), 32'd0);
        check("midreset/busy", 32'(bus.busy), 32'd1);
        settle_frame("resettle", 1, vecs[7].mode, vecs[7].idx, vecs[7].color, vecs[7].mask);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
